individual_fitness_harness: RTL and testbench

- Sequential evaluation stage wrapped around one evolved combinational individual. The individual has four W-bit inputs (a1, a0, b1, b0) and four W-bit outputs (y3..y0).
- Accepts a valid/ready stream of test vectors with golden outputs, drives each vector into the individual from registers, and captures the individual's outputs one cycle later.
- Accumulates a bitwise fitness score plus an exact-match count over NUM_VEC vectors, then reports both to the GE controller.

---
 rtl/individual_fitness_harness.sv | 149 ++++++++++++++
 tb/tb_individual_fitness_harness.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/individual_fitness_harness.sv
// Purpose: drives test vectors into one evolved combinational individual and scores its outputs.
// Latency: compare one cycle after each accepted vector; done pulses the cycle after the final compare.
// Backpressure: in_ready is high only in RUN; gaps in in_valid simply skip compare slots.
module individual_fitness_harness #(
  parameter int W       = 16,
  parameter int NUM_VEC = 64,
  parameter int SCORE_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a1,
  input  logic [W-1:0]       in_a0,
  input  logic [W-1:0]       in_b1,
  input  logic [W-1:0]       in_b0,
  input  logic [W-1:0]       in_e3,
  input  logic [W-1:0]       in_e2,
  input  logic [W-1:0]       in_e1,
  input  logic [W-1:0]       in_e0,
  output logic [W-1:0]       dut_a1,
  output logic [W-1:0]       dut_a0,
  output logic [W-1:0]       dut_b1,
  output logic [W-1:0]       dut_b0,
  input  logic [W-1:0]       dut_y3,
  input  logic [W-1:0]       dut_y2,
  input  logic [W-1:0]       dut_y1,
  input  logic [W-1:0]       dut_y0,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [CNT_W-1:0]   exact_cnt
);

  localparam int PW = $clog2(4*W+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic [W-1:0]       a1_q, a0_q, b1_q, b0_q;
  logic [4*W-1:0]     exp_q;
  logic               s1_valid_q;
  logic [CNT_W-1:0]   issue_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0]   exact_q, exact_d;

  logic               hs;
  logic               last_hs;
  logic               run_start;
  logic [4*W-1:0]     match_bits;
  logic [PW-1:0]      pop;
  logic [SCORE_W:0]   score_sum;

  assign in_ready  = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign hs        = in_valid & in_ready;
  assign last_hs   = hs && (issue_q == CNT_W'(NUM_VEC - 1));
  assign run_start = (state_q == S_IDLE) && start;

  assign dut_a1    = a1_q;
  assign dut_a0    = a0_q;
  assign dut_b1    = b1_q;
  assign dut_b0    = b0_q;
  assign done      = done_q;
  assign score     = score_q;
  assign exact_cnt = exact_q;

  // Next-state logic: IDLE waits for start, RUN counts handshakes, DRAIN lasts one cycle.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_hs) state_d = S_DRAIN;
      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and the one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Stage 1: capture accepted vector; operands hold between vectors so the individual sees stable inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q       <= '0;
      a0_q       <= '0;
      b1_q       <= '0;
      b0_q       <= '0;
      exp_q      <= '0;
      s1_valid_q <= 1'b0;
      issue_q    <= '0;
    end else begin
      s1_valid_q <= hs;
      if (run_start) begin
        issue_q <= '0;
      end else if (hs) begin
        a1_q  <= in_a1;
        a0_q  <= in_a0;
        b1_q  <= in_b1;
        b0_q  <= in_b0;
        exp_q <= {in_e3, in_e2, in_e1, in_e0};
        if (!(&issue_q)) issue_q <= issue_q + CNT_W'(1);
      end
    end
  end

  // Stage 2 compare: count agreeing bits and detect a fully exact vector, saturating both totals.
  always_comb begin
    match_bits = ~({dut_y3, dut_y2, dut_y1, dut_y0} ^ exp_q);
    pop        = '0;
    for (int i = 0; i < 4*W; i++) begin
      pop = pop + PW'(match_bits[i]);
    end
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(pop);
    score_d   = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    exact_d   = exact_q;
    if ((&match_bits) && !(&exact_q)) exact_d = exact_q + CNT_W'(1);
  end

  // Result accumulators: cleared by an accepted start, otherwise updated only on a valid stage-1 slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      exact_q <= '0;
    end else if (run_start) begin
      score_q <= '0;
      exact_q <= '0;
    end else if (s1_valid_q) begin
      score_q <= score_d;
      exact_q <= exact_d;
    end
  end

endmodule

// File: tb/tb_individual_fitness_harness.sv
// Bench for individual_fitness_harness: table of runs plus hand-written abort/misuse sequences.
// Expected scores come from counting agreeing bits of model output against the golden words.
// The individual is a fixed arithmetic function modelled in the bench.
module tb_individual_fitness_harness;

  localparam int W  = 16;
  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a1, in_a0, in_b1, in_b0;
  logic [W-1:0]  in_e3, in_e2, in_e1, in_e0;
  logic [W-1:0]  dut_a1, dut_a0, dut_b1, dut_b0;
  logic [W-1:0]  dut_y3, dut_y2, dut_y1, dut_y0;
  logic          done;
  logic [15:0]   score;
  logic [15:0]   exact_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int exp_s;
  int exp_e;

  typedef struct {
    int kind;       // 0 match, 1 all bits wrong, 2 one bit flipped, 3 random corruption
    int gap;        // idle cycles between vectors
    int flip_vec;   // vector index for kind 2
    int exp_score;  // -1: take from reference model
    int exp_exact;
  } case_t;

  case_t tbl[7];

  always #5 clk = ~clk;

  // The evolved individual under evaluation.
  function automatic logic [4*W-1:0] indiv(input logic [W-1:0] a1, a0, b1, b0);
    return {a1 + b1, a0 ^ b0, a1 & b0, a0 - b1};
  endfunction

  assign {dut_y3, dut_y2, dut_y1, dut_y0} = indiv(dut_a1, dut_a0, dut_b1, dut_b0);

  individual_fitness_harness #(.W(W), .NUM_VEC(NV), .SCORE_W(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a1(in_a1), .in_a0(in_a0), .in_b1(in_b1), .in_b0(in_b0),
    .in_e3(in_e3), .in_e2(in_e2), .in_e1(in_e1), .in_e0(in_e0),
    .dut_a1(dut_a1), .dut_a0(dut_a0), .dut_b1(dut_b1), .dut_b0(dut_b0),
    .dut_y3(dut_y3), .dut_y2(dut_y2), .dut_y1(dut_y1), .dut_y0(dut_y0),
    .done(done), .score(score), .exact_cnt(exact_cnt)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_s = 0;
    exp_e = 0;
    chk("busy_after_start", busy, 1);
  endtask

  // Present one vector for one cycle and update the reference totals.
  task automatic feed(input int kind, input int idx, input int flip);
    logic [4*W-1:0] y, e, mask;
    logic [W-1:0]   a1, a0, b1, b0;
    int             m;
    a1 = W'($urandom); a0 = W'($urandom); b1 = W'($urandom); b0 = W'($urandom);
    y  = indiv(a1, a0, b1, b0);
    mask = '0;
    case (kind)
      1: mask = '1;
      2: if (idx == flip) mask[$urandom_range(0, W-1)] = 1'b1;
      3: for (int k = 0; k < 4; k++) begin
           if ($urandom_range(0, 2) == 0) mask[k*W +: W] = W'($urandom);
           else if ($urandom_range(0, 1) == 1) mask[k*W + $urandom_range(0, W-1)] = 1'b1;
         end
      default: mask = '0;
    endcase
    e = y ^ mask;
    m = 0;
    for (int k = 0; k < 4*W; k++) if (y[k] == e[k]) m++;
    exp_s = (exp_s + m > 65535) ? 65535 : exp_s + m;
    if (y == e && exp_e < 65535) exp_e++;
    chk("in_ready_run", in_ready, 1);
    {in_a1, in_a0, in_b1, in_b0} = {a1, a0, b1, b0};
    {in_e3, in_e2, in_e1, in_e0} = e;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("dut_a1_captured", dut_a1, a1);
  endtask

  // Called right after the last handshake edge: done must appear after exactly one more edge.
  task automatic finish_run(input int es, input int ee, input bit restart);
    chk("done_not_early", done, 0);
    tick();
    chk("done_pulse", done, 1);
    chk("score_final", score, es);
    chk("exact_final", exact_cnt, ee);
    if (restart) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_busy", busy, 1);
      chk("restart_score_clr", score, 0);
      chk("restart_exact_clr", exact_cnt, 0);
      exp_s = 0;
      exp_e = 0;
    end else begin
      tick();
      chk("done_single", done, 0);
      chk("busy_idle", busy, 0);
      chk("score_hold", score, es);
    end
  endtask

  task automatic run_case(input case_t c, input bit restart);
    begin_run();
    for (int i = 0; i < NV; i++) begin
      feed(c.kind, i, c.flip_vec);
      if (i < NV-1) repeat (c.gap) tick();
    end
    finish_run(c.exp_score < 0 ? exp_s : c.exp_score,
               c.exp_exact < 0 ? exp_e : c.exp_exact, restart);
  endtask

  initial begin
    tbl[0] = '{0, 0, -1, 256, 4};
    tbl[1] = '{1, 0, -1, 0, 0};
    tbl[2] = '{2, 0, 1, 255, 3};
    tbl[3] = '{0, 2, -1, 256, 4};
    tbl[4] = '{3, 0, -1, -1, -1};
    tbl[5] = '{3, 1, -1, -1, -1};
    tbl[6] = '{3, 3, -1, -1, -1};

    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    {in_a1, in_a0, in_b1, in_b0} = 64'($urandom) << 32 | 64'($urandom);
    {in_e3, in_e2, in_e1, in_e0} = 64'($urandom);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_score", score, 0);
    chk("rst_exact", exact_cnt, 0);
    chk("rst_dut_a", {dut_a1, dut_a0, dut_b1, dut_b0}, 0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // in_valid while IDLE must not be taken.
    in_valid = 1'b1;
    in_a1 = 16'hBEEF;
    repeat (3) begin
      tick();
      chk("idle_in_ready", in_ready, 0);
      chk("idle_no_capture", dut_a1, 0);
    end
    in_valid = 1'b0;

    for (int t = 0; t < 7; t++) run_case(tbl[t], 1'b0);

    // start coincident with done begins a new run; then abort it with rst after two handshakes.
    run_case(tbl[0], 1'b1);
    feed(0, 0, -1);
    feed(0, 1, -1);
    chk("abort_partial_score", score, 64);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_score", score, 0);
    chk("abort_exact", exact_cnt, 0);
    chk("abort_dut_a", {dut_a1, dut_a0, dut_b1, dut_b0}, 0);
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("abort_no_done", done, 0);
      chk("abort_idle", in_ready, 0);
    end

    // start asserted mid-run is ignored; the run completes with the full score.
    begin_run();
    feed(0, 0, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run_score", score, 64);
    for (int i = 1; i < NV; i++) feed(0, i, -1);
    finish_run(256, 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1);
  end

endmodule
